gpio_bus_arbiter: RTL and testbench

GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

---
 rtl/gpio_bus_arbiter_if.sv | 53 +++++
 rtl/gpio_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle for gpio_bus_arbiter: two master request channels, the shared
// register-slave bus and the per-master statistics counters.
// The slave modport is the arbiter's view (it answers the masters and drives
// the register slave); the master modport is the environment's view.
interface gpio_bus_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              s_we;
  logic              s_re;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  logic [15:0]       cnt0;
  logic [15:0]       cnt1;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  s_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output s_we, s_re, s_addr, s_wdata,
    output cnt0, cnt1
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output s_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  s_we, s_re, s_addr, s_wdata,
    input  cnt0, cnt1
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-master round-robin arbiter in front of a single
// register slave. Each transaction is IDLE (arbitrate + latch) -> ACCESS
// (one slave strobe) -> RESP (one done pulse), so throughput is one access
// every three cycles. All outputs come straight from flops.
// Optional feature: define GPIO_ARB_STATS_EN to enable the saturating
// per-master completed-transaction counters cnt0/cnt1; without it they read 0.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  gpio_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;

  // last_r: 1 = master 1 was granted last, so master 0 wins the next tie.
  logic              last_r;
  logic              owner_r;

  logic              req_any_s;
  logic              win_s;
  logic              win_wr_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  // The slave-bus registers double as the latched request: they are loaded
  // when leaving IDLE and are only non-zero for the single ACCESS cycle.
  logic              s_we_r;
  logic              s_re_r;
  logic [ADDR_W-1:0] s_addr_r;
  logic [DATA_W-1:0] s_wdata_r;

  logic              gnt0_r;
  logic              gnt1_r;
  logic              done0_r;
  logic              done1_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  // Round-robin winner selection and the winner's request fields.
  always_comb begin
    req_any_s   = bus.m0_req | bus.m1_req;
    win_s       = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      win_s = ~last_r;
    end else if (bus.m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    win_wr_s    = win_s ? bus.m1_wr    : bus.m0_wr;
    win_addr_s  = win_s ? bus.m1_addr  : bus.m0_addr;
    win_wdata_s = win_s ? bus.m1_wdata : bus.m0_wdata;
  end

  // Next-state logic: IDLE waits for a request, ACCESS and RESP last one cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          state_nx_s = ACCESS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS:  state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Slave strobes/address/data: loaded from the winner on leaving IDLE, zero otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_we_r    <= 1'b0;
      s_re_r    <= 1'b0;
      s_addr_r  <= {ADDR_W{1'b0}};
      s_wdata_r <= {DATA_W{1'b0}};
    end else if (state_r == IDLE && req_any_s) begin
      s_we_r    <= win_wr_s;
      s_re_r    <= ~win_wr_s;
      s_addr_r  <= win_addr_s;
      s_wdata_r <= win_wdata_s;
    end else begin
      s_we_r    <= 1'b0;
      s_re_r    <= 1'b0;
      s_addr_r  <= {ADDR_W{1'b0}};
      s_wdata_r <= {DATA_W{1'b0}};
    end
  end

  // Ownership, grants (ACCESS+RESP) and the one-cycle done pulse (RESP).
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_r <= 1'b0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
    end else begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            owner_r <= win_s;
            gnt0_r  <= ~win_s;
            gnt1_r  <= win_s;
          end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
          end
        end
        ACCESS: begin
          done0_r <= ~owner_r;
          done1_r <= owner_r;
        end
        RESP: begin
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
        end
        default: begin
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
        end
      endcase
    end
  end

  // Round-robin pointer: records the owner once its transaction completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else if (state_r == RESP) begin
      last_r <= owner_r;
    end else begin
      last_r <= last_r;
    end
  end

  // Read-data capture at the end of a read ACCESS; writes leave rdata untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
    end else if (state_r == ACCESS && s_re_r) begin
      if (owner_r) begin
        rdata1_r <= bus.s_rdata;
      end else begin
        rdata0_r <= bus.s_rdata;
      end
    end else begin
      rdata0_r <= rdata0_r;
      rdata1_r <= rdata1_r;
    end
  end

`ifdef GPIO_ARB_STATS_EN
  logic [15:0] cnt0_r;
  logic [15:0] cnt1_r;

  // Saturating per-master completion counters, bumped in RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0_r <= 16'h0000;
      cnt1_r <= 16'h0000;
    end else if (state_r == RESP) begin
      if (!owner_r && cnt0_r != 16'hFFFF) begin
        cnt0_r <= cnt0_r + 16'd1;
      end else begin
        cnt0_r <= cnt0_r;
      end
      if (owner_r && cnt1_r != 16'hFFFF) begin
        cnt1_r <= cnt1_r + 16'd1;
      end else begin
        cnt1_r <= cnt1_r;
      end
    end else begin
      cnt0_r <= cnt0_r;
      cnt1_r <= cnt1_r;
    end
  end

  assign bus.cnt0 = cnt0_r;
  assign bus.cnt1 = cnt1_r;
`else
  assign bus.cnt0 = 16'h0000;
  assign bus.cnt1 = 16'h0000;
`endif

  assign bus.s_we     = s_we_r;
  assign bus.s_re     = s_re_r;
  assign bus.s_addr   = s_addr_r;
  assign bus.s_wdata  = s_wdata_r;
  assign bus.m0_gnt   = gnt0_r;
  assign bus.m1_gnt   = gnt1_r;
  assign bus.m0_done  = done0_r;
  assign bus.m1_done  = done1_r;
  assign bus.m0_rdata = rdata0_r;
  assign bus.m1_rdata = rdata1_r;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed self-checking bench for gpio_bus_arbiter. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at that same point.
module tb_gpio_bus_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk;
  logic reset;
  int   check_cnt;
  int   pass_cnt;

  gpio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  gpio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One complete transaction for a single master; req drops after the grant.
  task automatic do_txn(input bit m, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    if (m) begin
      bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
    end else begin
      bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
    end
    tick();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++; if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0) $display("FAIL rst_gnt: got %b%b want 00", bus.m0_gnt, bus.m1_gnt); else pass_cnt++;
    check_cnt++; if (bus.m0_done !== 1'b0 || bus.m1_done !== 1'b0) $display("FAIL rst_done: got %b%b want 00", bus.m0_done, bus.m1_done); else pass_cnt++;
    check_cnt++; if (bus.s_we !== 1'b0 || bus.s_re !== 1'b0) $display("FAIL rst_strobe: got we=%b re=%b want 0 0", bus.s_we, bus.s_re); else pass_cnt++;
    check_cnt++; if (bus.s_addr !== 4'h0 || bus.s_wdata !== 32'h0) $display("FAIL rst_sbus: got %h %h want 0 0", bus.s_addr, bus.s_wdata); else pass_cnt++;
    check_cnt++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) $display("FAIL rst_rdata: got %h %h want 0 0", bus.m0_rdata, bus.m1_rdata); else pass_cnt++;
    check_cnt++; if (bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0) $display("FAIL rst_cnt: got %h %h want 0 0", bus.cnt0, bus.cnt1); else pass_cnt++;
  endtask

  task automatic test_write();
    bus.m0_wr = 1'b1; bus.m0_addr = 4'h0; bus.m0_wdata = 32'hA5A5_0001; bus.m0_req = 1'b1;
    tick();
    bus.m0_wdata = 32'hFFFF_FFFF;  // late change must be ignored
    check_cnt++; if (bus.s_we !== 1'b1 || bus.s_re !== 1'b0) $display("FAIL wr_strobe: got we=%b re=%b want 1 0", bus.s_we, bus.s_re); else pass_cnt++;
    check_cnt++; if (bus.s_addr !== 4'h0 || bus.s_wdata !== 32'hA5A5_0001) $display("FAIL wr_sbus: got %h %h want 0 a5a50001", bus.s_addr, bus.s_wdata); else pass_cnt++;
    check_cnt++; if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0 || bus.m0_done !== 1'b0) $display("FAIL wr_gnt: got g0=%b g1=%b d0=%b want 1 0 0", bus.m0_gnt, bus.m1_gnt, bus.m0_done); else pass_cnt++;
    tick();
    bus.m0_req = 1'b0;
    check_cnt++; if (bus.m0_done !== 1'b1 || bus.m0_gnt !== 1'b1) $display("FAIL wr_done: got d0=%b g0=%b want 1 1", bus.m0_done, bus.m0_gnt); else pass_cnt++;
    check_cnt++; if (bus.s_we !== 1'b0 || bus.s_wdata !== 32'h0) $display("FAIL wr_strobe_off: got we=%b wdata=%h want 0 0", bus.s_we, bus.s_wdata); else pass_cnt++;
    tick();
    check_cnt++; if (bus.m0_done !== 1'b0 || bus.m0_gnt !== 1'b0) $display("FAIL wr_idle: got d0=%b g0=%b want 0 0", bus.m0_done, bus.m0_gnt); else pass_cnt++;
    check_cnt++; if (bus.m0_rdata !== 32'h0) $display("FAIL wr_rdata: got %h want 0", bus.m0_rdata); else pass_cnt++;
  endtask

  task automatic test_read();
    bus.m1_wr = 1'b0; bus.m1_addr = 4'h4; bus.m1_wdata = 32'h1111_2222; bus.m1_req = 1'b1;
    bus.s_rdata = 32'h0000_00FF;
    tick();
    check_cnt++; if (bus.s_re !== 1'b1 || bus.s_we !== 1'b0) $display("FAIL rd_strobe: got re=%b we=%b want 1 0", bus.s_re, bus.s_we); else pass_cnt++;
    check_cnt++; if (bus.s_addr !== 4'h4 || bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) $display("FAIL rd_addr_gnt: got %h g1=%b g0=%b want 4 1 0", bus.s_addr, bus.m1_gnt, bus.m0_gnt); else pass_cnt++;
    tick();
    bus.m1_req = 1'b0;
    bus.s_rdata = 32'h0;
    check_cnt++; if (bus.m1_done !== 1'b1 || bus.m1_rdata !== 32'h0000_00FF) $display("FAIL rd_done: got d1=%b rdata=%h want 1 000000ff", bus.m1_done, bus.m1_rdata); else pass_cnt++;
    check_cnt++; if (bus.s_re !== 1'b0 || bus.m0_rdata !== 32'h0 || bus.m0_done !== 1'b0) $display("FAIL rd_other: got re=%b r0=%h d0=%b want 0 0 0", bus.s_re, bus.m0_rdata, bus.m0_done); else pass_cnt++;
    tick();
    check_cnt++; if (bus.m1_rdata !== 32'h0000_00FF || bus.m1_done !== 1'b0) $display("FAIL rd_hold: got rdata=%h d1=%b want 000000ff 0", bus.m1_rdata, bus.m1_done); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int t;
    int ph;
    bit exp_m;
    do_reset();
    bus.m0_wr = 1'b0; bus.m0_addr = 4'h1; bus.m0_req = 1'b1;
    bus.m1_wr = 1'b0; bus.m1_addr = 4'h2; bus.m1_req = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    for (int k = 1; k <= 12; k++) begin
      tick();
      t = (k - 1) / 3;
      ph = (k - 1) % 3;
      exp_m = t[0];
      check_cnt++; if ((bus.m0_gnt & bus.m1_gnt) !== 1'b0 || (bus.m0_done & bus.m1_done) !== 1'b0) $display("FAIL rr_excl cyc%0d: got g=%b%b d=%b%b", k, bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done); else pass_cnt++;
      if (ph == 0) begin
        check_cnt++; if (bus.m0_gnt !== !exp_m || bus.m1_gnt !== exp_m || bus.s_re !== 1'b1 || bus.s_addr !== (exp_m ? 4'h2 : 4'h1)) $display("FAIL rr_access cyc%0d: got g=%b%b re=%b a=%h want m%0d", k, bus.m0_gnt, bus.m1_gnt, bus.s_re, bus.s_addr, exp_m); else pass_cnt++;
      end else if (ph == 1) begin
        check_cnt++; if (bus.m0_done !== !exp_m || bus.m1_done !== exp_m) $display("FAIL rr_done cyc%0d: got d=%b%b want m%0d", k, bus.m0_done, bus.m1_done, exp_m); else pass_cnt++;
      end else begin
        check_cnt++; if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.s_re !== 1'b0) $display("FAIL rr_idle cyc%0d: got g=%b%b re=%b want 0", k, bus.m0_gnt, bus.m1_gnt, bus.s_re); else pass_cnt++;
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    check_cnt++; if (bus.m0_rdata !== 32'h1234_5678 || bus.m1_rdata !== 32'h1234_5678) $display("FAIL rr_rdata: got %h %h want 12345678", bus.m0_rdata, bus.m1_rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_abort();
    bus.m0_wr = 1'b1; bus.m0_addr = 4'h5; bus.m0_wdata = 32'hDEAD_BEEF; bus.m0_req = 1'b1;
    tick();
    check_cnt++; if (bus.s_we !== 1'b1 || bus.s_addr !== 4'h5) $display("FAIL abort_access: got we=%b a=%h want 1 5", bus.s_we, bus.s_addr); else pass_cnt++;
    reset = 1'b0;
    tick();
    check_cnt++; if (bus.m0_done !== 1'b0 || bus.m0_gnt !== 1'b0) $display("FAIL abort_done: got d0=%b g0=%b want 0 0", bus.m0_done, bus.m0_gnt); else pass_cnt++;
    check_cnt++; if (bus.s_we !== 1'b0 || bus.s_addr !== 4'h0 || bus.s_wdata !== 32'h0) $display("FAIL abort_sbus: got we=%b a=%h d=%h want 0", bus.s_we, bus.s_addr, bus.s_wdata); else pass_cnt++;
    check_cnt++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) $display("FAIL abort_rdata: got %h %h want 0 0", bus.m0_rdata, bus.m1_rdata); else pass_cnt++;
    reset = 1'b1;
    bus.m0_req = 1'b0;
    tick();
    check_cnt++; if (bus.m0_done !== 1'b0 || bus.s_we !== 1'b0) $display("FAIL abort_after: got d0=%b we=%b want 0 0", bus.m0_done, bus.s_we); else pass_cnt++;
    bus.m1_wr = 1'b0; bus.m1_addr = 4'h6; bus.m1_req = 1'b1;
    bus.s_rdata = 32'h0BAD_F00D;
    tick();
    bus.m1_req = 1'b0;
    check_cnt++; if (bus.m1_gnt !== 1'b1 || bus.s_re !== 1'b1 || bus.s_addr !== 4'h6) $display("FAIL abort_idle: got g1=%b re=%b a=%h want 1 1 6", bus.m1_gnt, bus.s_re, bus.s_addr); else pass_cnt++;
    tick();
    check_cnt++; if (bus.m1_done !== 1'b1 || bus.m1_rdata !== 32'h0BAD_F00D) $display("FAIL abort_resume: got d1=%b r1=%h want 1 0badf00d", bus.m1_done, bus.m1_rdata); else pass_cnt++;
    bus.s_rdata = 32'h0;
    tick();
  endtask

  task automatic test_req_drop();
    int done_seen;
    int strobe_seen;
    done_seen = 0;
    strobe_seen = 0;
    bus.m0_wr = 1'b1; bus.m0_addr = 4'h3; bus.m0_wdata = 32'h0000_0033; bus.m0_req = 1'b1;
    tick();
    check_cnt++; if (bus.s_we !== 1'b1 || bus.s_wdata !== 32'h0000_0033) $display("FAIL drop_access: got we=%b d=%h want 1 00000033", bus.s_we, bus.s_wdata); else pass_cnt++;
    bus.m0_req = 1'b0;
    bus.m0_addr = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.m0_done === 1'b1) done_seen++;
      if (bus.s_we === 1'b1 || bus.s_re === 1'b1) strobe_seen++;
    end
    check_cnt++; if (done_seen !== 1) $display("FAIL drop_done: got %0d pulses want 1", done_seen); else pass_cnt++;
    check_cnt++; if (strobe_seen !== 0) $display("FAIL drop_strobe: got %0d strobes want 0", strobe_seen); else pass_cnt++;
  endtask

  task automatic test_counters();
    logic [15:0] exp0;
    logic [15:0] exp1;
    do_reset();
    do_txn(1'b0, 1'b1, 4'h1, 32'h0000_0001);
    do_txn(1'b1, 1'b0, 4'h2, 32'h0);
    do_txn(1'b0, 1'b0, 4'h3, 32'h0);
    do_txn(1'b1, 1'b1, 4'h4, 32'h0000_0004);
    do_txn(1'b0, 1'b1, 4'h5, 32'h0000_0005);
`ifdef GPIO_ARB_STATS_EN
    exp0 = 16'd3;
    exp1 = 16'd2;
`else
    exp0 = 16'd0;
    exp1 = 16'd0;
`endif
    check_cnt++; if (bus.cnt0 !== exp0) $display("FAIL cnt0: got %0d want %0d", bus.cnt0, exp0); else pass_cnt++;
    check_cnt++; if (bus.cnt1 !== exp1) $display("FAIL cnt1: got %0d want %0d", bus.cnt1, exp1); else pass_cnt++;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt = 0;
    reset = 1'b0;
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = 4'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = 4'h0; bus.m1_wdata = 32'h0;
    bus.s_rdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_abort();
    test_req_drop();
    test_counters();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
